// File: rtl/mc_ctrl_if.sv
// Control/status bundle between mc_ctrl (master) and the MIPS datapath/memories (slave).
// Carries IR and ALU status in, every datapath select/enable and memory request out.
interface mc_ctrl_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_re;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [1:0]  EXTop;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        dmem_re;
  logic        dmem_we;
  logic        illegal;
  logic        bus_err;
  logic [2:0]  state;

  modport master (
    input  instr, alu_zero, imem_ready, dmem_ready,
    output imem_re, ir_we, pc_we, pc_sel, EXTop, alu_op, alu_src, reg_we,
           reg_dst, wd_sel, dmem_re, dmem_we, illegal, bus_err, state
  );

  modport slave (
    output instr, alu_zero, imem_ready, dmem_ready,
    input  imem_re, ir_we, pc_we, pc_sel, EXTop, alu_op, alu_src, reg_we,
           reg_dst, wd_sel, dmem_re, dmem_we, illegal, bus_err, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: 2-5 cycles per instruction plus memory wait cycles.
// Stalls in FETCH/MEM until ready; gives up after WAIT_MAX cycles with a bus_err pulse.
module mc_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input logic       clk,
  input logic       rst_n,
  mc_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL
  } cls_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t         st;
  logic [5:0]     op_q;
  logic [5:0]     fn_q;
  logic [CNT_W-1:0] wcnt;
  logic           illegal_q;
  logic           bus_err_q;
  cls_t           cls;
  logic           timeout;

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    cls_t c;
    c = C_ILL;
    case (op)
      6'h00: begin
        case (fn)
          6'h21:   c = C_ADDU;
          6'h23:   c = C_SUBU;
          6'h08:   c = C_JR;
          default: c = C_ILL;
        endcase
      end
      6'h02:   c = C_J;
      6'h03:   c = C_JAL;
      6'h04:   c = C_BEQ;
      6'h0D:   c = C_ORI;
      6'h0F:   c = C_LUI;
      6'h23:   c = C_LW;
      6'h2B:   c = C_SW;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  // DECODE looks at the live IR; later states use the opcode/funct captured there.
  always_comb begin
    if (st == S_DECODE)
      cls = (bus.instr == 32'd0) ? C_NOP : classify(bus.instr[31:26], bus.instr[5:0]);
    else
      cls = classify(op_q, fn_q);
  end

  assign timeout = (wcnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_RESET;
      op_q      <= '0;
      fn_q      <= '0;
      wcnt      <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      case (st)
        S_RESET: begin
          wcnt <= '0;
          st   <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.imem_ready) begin
            wcnt <= '0;
            st   <= S_DECODE;
          end else if (timeout) begin
            wcnt      <= '0;
            bus_err_q <= 1'b1;
          end else begin
            wcnt <= wcnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          op_q <= bus.instr[31:26];
          fn_q <= bus.instr[5:0];
          case (cls)
            C_J, C_NOP: st <= S_FETCH;
            C_ILL: begin
              illegal_q <= 1'b1;
              st        <= S_FETCH;
            end
            C_JAL:   st <= S_WB;
            default: st <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls)
            C_LW, C_SW:  st <= S_MEM;
            C_BEQ, C_JR: st <= S_FETCH;
            default:     st <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            wcnt <= '0;
            st   <= (cls == C_LW) ? S_WB : S_FETCH;
          end else if (timeout) begin
            wcnt      <= '0;
            bus_err_q <= 1'b1;
            st        <= S_FETCH;
          end else begin
            wcnt <= wcnt + CNT_W'(1);
          end
        end
        S_WB:    st <= S_FETCH;
        default: st <= S_RESET;
      endcase
    end
  end

  always_comb begin
    bus.imem_re = 1'b0;
    bus.ir_we   = 1'b0;
    bus.pc_we   = 1'b0;
    bus.pc_sel  = 2'd0;
    bus.EXTop   = 2'd0;
    bus.alu_op  = 3'd0;
    bus.alu_src = 1'b0;
    bus.reg_we  = 1'b0;
    bus.reg_dst = 2'd0;
    bus.wd_sel  = 2'd0;
    bus.dmem_re = 1'b0;
    bus.dmem_we = 1'b0;
    case (st)
      S_FETCH: begin
        bus.imem_re = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
        end
      end
      S_DECODE: begin
        if (cls == C_J) begin
          bus.pc_we  = 1'b1;
          bus.pc_sel = 2'd2;
        end
      end
      S_EXEC: begin
        case (cls)
          C_SUBU: bus.alu_op = 3'd1;
          C_ORI: begin
            bus.EXTop = 2'd1; bus.alu_op = 3'd2; bus.alu_src = 1'b1;
          end
          C_LUI: begin
            bus.EXTop = 2'd3; bus.alu_op = 3'd3; bus.alu_src = 1'b1;
          end
          C_LW, C_SW: begin
            bus.EXTop = 2'd2; bus.alu_src = 1'b1;
          end
          C_BEQ: begin
            bus.EXTop = 2'd2; bus.alu_op = 3'd1;
            bus.pc_we = bus.alu_zero; bus.pc_sel = 2'd1;
          end
          C_JR: begin
            bus.pc_we = 1'b1; bus.pc_sel = 2'd3;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // Hold the address path steady for the whole access.
        bus.EXTop   = 2'd2;
        bus.alu_src = 1'b1;
        bus.dmem_re = (cls == C_LW);
        bus.dmem_we = (cls == C_SW);
      end
      S_WB: begin
        bus.reg_we = 1'b1;
        case (cls)
          C_ADDU, C_SUBU: bus.reg_dst = 2'd1;
          C_LW:           bus.wd_sel  = 2'd1;
          C_JAL: begin
            bus.reg_dst = 2'd2; bus.wd_sel = 2'd2;
            bus.pc_we   = 1'b1; bus.pc_sel = 2'd2;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;
  assign bus.state   = st;
endmodule
